// File: rtl/nic_pe_interface_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nic_pe_interface_pkg
//  Description : Shared definitions for the NIC / mesh router PE port.
//                Packet layout:
//                {vc[63], dir[62:61], rsvd[60:56], hop[55:48],
//                 src[47:32], payload[31:0]}
//                It also holds the processor register-map address codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package nic_pe_interface_pkg;

   localparam int DATA_WIDTH = 64;

   // Packet field offsets
   localparam int VC_BIT  = 63;
   localparam int DIR_MSB = 62;
   localparam int DIR_LSB = 61;
   localparam int HOP_MSB = 55;
   localparam int HOP_LSB = 48;
   localparam int SRC_MSB = 47;
   localparam int SRC_LSB = 32;

   // Processor register map
   typedef enum logic [1:0] {
      ADDR_IN_BUF   = 2'b00,
      ADDR_IN_STAT  = 2'b01,
      ADDR_OUT_BUF  = 2'b10,
      ADDR_OUT_STAT = 2'b11
   } nic_addr_e;

   typedef struct packed {
      logic        vc;
      logic [1:0]  dir;
      logic [4:0]  rsvd;
      logic [7:0]  hop;
      logic [15:0] src;
      logic [31:0] payload;
   } nic_pkt_t;

   // Virtual-channel bit of a packet. The router only accepts a packet
   // on cycles whose polarity differs from this bit.
   function automatic logic pkt_vc(input logic [DATA_WIDTH-1:0] pkt);
      return pkt[VC_BIT];
   endfunction

endpackage : nic_pe_interface_pkg
`default_nettype wire

// File: rtl/nic_channel_buf.sv
`default_nettype none
// ============================================================================
//  Module      : nic_channel_buf
//  Description : One-entry channel buffer with a full flag.
//                - load : capture din and set full. This is ignored while
//                         the buffer is already full.
//                - clear: drop full. The data register keeps its value.
//  Ports       : clk, reset (async, active-low), load, clear,
//                din[DATA_WIDTH], dout[DATA_WIDTH], full
//  Revision    : 1.0 - initial release
// ============================================================================
module nic_channel_buf #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_full;

   // When load and clear are both asserted, load can only take effect on
   // an empty buffer. Clear is then a no-op, so the order of the two
   // checks below matters only for the full case, where clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data <= '0;
         r_full <= 1'b0;
      end else if (load && !r_full) begin
         r_data <= din;
         r_full <= 1'b1;
      end else if (clear) begin
         r_full <= 1'b0;
      end
   end

   assign dout = r_data;
   assign full = r_full;

endmodule : nic_channel_buf
`default_nettype wire

// File: rtl/nic_pe_interface.sv
`default_nettype none
// ============================================================================
//  Module      : nic_pe_interface
//  Description : Network interface between a processing element and the PE
//                port of one mesh router. It provides two one-entry channel
//                buffers (input and output) and a 4-word register map.
//  Ports       : clk, reset (async, active-low)
//                addr[2], d_in[64], d_out[64], nicEn, nicWrEn : processor
//                net_si, net_ri, net_di[64]                   : router -> NIC
//                net_so, net_ro, net_do[64]                   : NIC -> router
//                net_polarity                                 : even/odd cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module nic_pe_interface #(
   parameter int DATA_WIDTH = nic_pe_interface_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [DATA_WIDTH-1:0] net_di,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_polarity
);

   import nic_pe_interface_pkg::*;

   logic                  w_rd;
   logic                  w_wr;
   logic                  w_in_load;
   logic                  w_in_clear;
   logic                  w_out_load;
   logic [DATA_WIDTH-1:0] w_in_data;
   logic [DATA_WIDTH-1:0] w_out_data;
   logic                  w_in_full;
   logic                  w_out_full;

   assign w_rd = nicEn & ~nicWrEn;
   assign w_wr = nicEn &  nicWrEn;

   // ------------------------------------------------------------------
   // Input path (router -> processor)
   // ------------------------------------------------------------------
   assign net_ri     = ~w_in_full;
   assign w_in_load  = net_si & net_ri;
   assign w_in_clear = w_rd & (addr == ADDR_IN_BUF);

   nic_channel_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_in_buf (
      .clk   (clk),
      .reset (reset),
      .load  (w_in_load),
      .clear (w_in_clear),
      .din   (net_di),
      .dout  (w_in_data),
      .full  (w_in_full)
   );

   // ------------------------------------------------------------------
   // Output path (processor -> router)
   // ------------------------------------------------------------------
   // A write to a full output buffer is dropped. This includes a write in
   // the same cycle as a send, because full is still set before the edge.
   // The buffer enforces the drop internally.
   assign w_out_load = w_wr & (addr == ADDR_OUT_BUF);

   nic_channel_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk   (clk),
      .reset (reset),
      .load  (w_out_load),
      .clear (net_so),
      .din   (d_in),
      .dout  (w_out_data),
      .full  (w_out_full)
   );

   // The router takes a packet only when its vc bit differs from the
   // current mesh polarity. The packet is forwarded unmodified.
   assign net_so = w_out_full & net_ro & (pkt_vc(w_out_data) != net_polarity);
   assign net_do = w_out_data;

   // ------------------------------------------------------------------
   // Processor read mux
   // ------------------------------------------------------------------
   always_comb begin
      d_out = '0;
      if (nicEn) begin
         case (nic_addr_e'(addr))
            ADDR_IN_BUF:   d_out = w_in_data;
            ADDR_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, w_in_full};
            ADDR_OUT_BUF:  d_out = w_out_data;
            ADDR_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, w_out_full};
            default:       d_out = '0;
         endcase
      end
   end

endmodule : nic_pe_interface
`default_nettype wire
